// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcode constants, ALU op / arbiter state enums, op decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLTU = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010
  } alu_op_e;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Non-ALU opcodes (load/store/branch/jumps) all fall back to ADD for address math.
  function automatic alu_op_e alu_encoder(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       funct7_b5);
    alu_op_e op;
    logic    is_r;
    op   = ALU_ADD;
    is_r = (opcode == c_opc_op);
    if (is_r || (opcode == c_opc_op_imm)) begin
      case (funct3)
        3'b000:  op = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_alu_core.sv
// ============================================================================
// Module  : alu_core
// Brief   : Combinational 32-bit integer ALU, (op, a, b) -> result
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int c_sh_w = $clog2(DATA_W);

  logic [c_sh_w-1:0] w_shamt;
  assign w_shamt = b[c_sh_w-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << w_shamt;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      default:  result = a + b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin share of one ALU between two requesters, 1-entry response
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [6:0]        i_req0_opcode,
  input  logic [2:0]        i_req0_funct3,
  input  logic [6:0]        i_req0_funct7,
  input  logic [DATA_W-1:0] i_req0_rs1,
  input  logic [DATA_W-1:0] i_req0_rs2,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [6:0]        i_req1_opcode,
  input  logic [2:0]        i_req1_funct3,
  input  logic [6:0]        i_req1_funct7,
  input  logic [DATA_W-1:0] i_req1_rs1,
  input  logic [DATA_W-1:0] i_req1_rs2,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_id,
  output logic              o_busy
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_data;
  logic              r_id;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_can_accept;
  logic              w_accept;
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [DATA_W-1:0] w_rs1;
  logic [DATA_W-1:0] w_rs2;
  alu_op_e           w_op;
  logic [DATA_W-1:0] w_result;
  logic              w_unused;

  // Contention goes to whichever requester did not win the last accept.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant0 = i_req0_valid;
      w_grant1 = i_req1_valid;
    end
  end

  assign w_can_accept = (r_state == EMPTY) | i_rsp_ready;
  assign o_req0_ready = w_can_accept & w_grant0;
  assign o_req1_ready = w_can_accept & w_grant1;
  assign w_accept     = o_req0_ready | o_req1_ready;

  assign w_opcode = w_grant1 ? i_req1_opcode : i_req0_opcode;
  assign w_funct3 = w_grant1 ? i_req1_funct3 : i_req0_funct3;
  assign w_funct7 = w_grant1 ? i_req1_funct7 : i_req0_funct7;
  assign w_rs1    = w_grant1 ? i_req1_rs1    : i_req0_rs1;
  assign w_rs2    = w_grant1 ? i_req1_rs2    : i_req0_rs2;
  assign w_unused = ^{w_funct7[6], w_funct7[4:0]};

  assign w_op = alu_encoder(w_opcode, w_funct3, w_funct7[5]);

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .op     (w_op),
    .a      (w_rs1),
    .b      (w_rs2),
    .result (w_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (i_rsp_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= EMPTY;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data       <= w_result;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
    end
  end

  assign o_rsp_valid = (r_state == FULL);
  assign o_rsp_data  = r_data;
  assign o_rsp_id    = r_id;
  assign o_busy      = o_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module  : tb_alu_share_arbiter
// Brief   : Directed self-checking bench for alu_share_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  localparam logic [6:0] c_r  = 7'b0110011;
  localparam logic [6:0] c_i  = 7'b0010011;
  localparam logic [6:0] c_ld = 7'b0000011;
  localparam logic [6:0] c_f0 = 7'b0000000;
  localparam logic [6:0] c_f1 = 7'b0100000;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [6:0]  req0_opcode, req1_opcode;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [6:0]  req0_funct7, req1_funct7;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int n_chk = 0;
  int n_err = 0;

  alu_share_arbiter #(.DATA_W(32)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req0_valid  (req0_valid),
    .o_req0_ready  (req0_ready),
    .i_req0_opcode (req0_opcode),
    .i_req0_funct3 (req0_funct3),
    .i_req0_funct7 (req0_funct7),
    .i_req0_rs1    (req0_rs1),
    .i_req0_rs2    (req0_rs2),
    .i_req1_valid  (req1_valid),
    .o_req1_ready  (req1_ready),
    .i_req1_opcode (req1_opcode),
    .i_req1_funct3 (req1_funct3),
    .i_req1_funct7 (req1_funct7),
    .i_req1_rs1    (req1_rs1),
    .i_req1_rs2    (req1_rs2),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_data    (rsp_data),
    .o_rsp_id      (rsp_id),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req1_opcode = opc; req1_funct3 = f3; req1_funct7 = f7; req1_rs1 = a; req1_rs2 = b;
    end else begin
      req0_opcode = opc; req0_funct3 = f3; req0_funct7 = f7; req0_rs1 = a; req0_rs2 = b;
    end
  endtask

  // Issues a lone request with the consumer always ready; result shows one cycle later.
  task automatic issue(input bit who, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    set_req(who, opc, f3, f7, a, b);
    req0_valid = !who;
    req1_valid = who;
    #1;
    check({tag, "_rdy"}, {31'b0, who ? req1_ready : req0_ready}, 32'd1);
    step();
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_id"}, {31'b0, rsp_id}, {31'b0, who});
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    set_req(1'b0, c_r, 3'b000, c_f0, 32'd1, 32'd2);
    set_req(1'b1, c_r, 3'b000, c_f0, 32'd10, 32'd20);
    repeat (3) step();
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_id", {31'b0, rsp_id}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // First contention after reset goes to req0
    rst = 1'b0;
    #1;
    check("first_rdy0", {31'b0, req0_ready}, 32'd1);
    check("first_rdy1", {31'b0, req1_ready}, 32'd0);
    step();
    check("first_valid", {31'b0, rsp_valid}, 32'd1);
    check("first_id", {31'b0, rsp_id}, 32'd0);
    check("first_data", rsp_data, 32'd3);
    check("next_rdy1", {31'b0, req1_ready}, 32'd1);

    // Continuous contention alternates grants, one result per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      check("fair_valid", {31'b0, rsp_valid}, 32'd1);
      check("fair_id", {31'b0, rsp_id}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("fair_data", rsp_data, (i % 2 == 0) ? 32'd30 : 32'd3);
    end

    // Backpressure holds id0/3 and blocks both requesters
    rsp_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy0", {31'b0, req0_ready}, 32'd0);
      check("bp_rdy1", {31'b0, req1_ready}, 32'd0);
      step();
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_id", {31'b0, rsp_id}, 32'd0);
      check("bp_data", rsp_data, 32'd3);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_refill_rdy1", {31'b0, req1_ready}, 32'd1);
    check("bp_refill_rdy0", {31'b0, req0_ready}, 32'd0);
    step();
    check("bp_refill_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp_refill_id", {31'b0, rsp_id}, 32'd1);
    check("bp_refill_data", rsp_data, 32'd30);

    // Idle requesters let the held result drain
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("drain_valid", {31'b0, rsp_valid}, 32'd0);
    check("drain_busy", {31'b0, busy}, 32'd0);

    // R-type and I-type decode/arithmetic
    issue(1'b0, c_r, 3'b000, c_f1, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
    issue(1'b0, c_r, 3'b101, c_f1, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    issue(1'b0, c_r, 3'b101, c_f0, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
    issue(1'b0, c_r, 3'b011, c_f0, 32'd1, 32'hFFFF_FFFF, 32'd1, "sltu");
    issue(1'b0, c_r, 3'b010, c_f0, 32'd1, 32'hFFFF_FFFF, 32'd0, "slt");
    issue(1'b0, c_r, 3'b001, c_f0, 32'd1, 32'h0000_0021, 32'd2, "sll_mask");
    issue(1'b1, c_i, 3'b000, c_f1, 32'd10, 32'd3, 32'd13, "addi_f7");
    issue(1'b1, c_ld, 3'b010, c_f0, 32'h100, 32'd8, 32'h108, "load_add");
    issue(1'b1, c_i, 3'b100, c_f0, 32'h0000_F0F0, 32'h0000_00FF, 32'h0000_F00F, "xori");
    issue(1'b0, c_r, 3'b110, c_f0, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, "or");
    issue(1'b0, c_r, 3'b111, c_f0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, "and");

    // Lone req1 is accepted every cycle
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, c_r, 3'b000, c_f0, 32'(i), 32'd100);
      #1;
      check("solo_rdy1", {31'b0, req1_ready}, 32'd1);
      check("solo_rdy0", {31'b0, req0_ready}, 32'd0);
      step();
      check("solo_id", {31'b0, rsp_id}, 32'd1);
      check("solo_data", rsp_data, 32'(i + 100));
    end

    // Async reset clears a held result without a clock edge
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("async_rst_data", rsp_data, 32'd0);
    check("async_rst_rdy1", {31'b0, req1_ready}, 32'd1);
    req1_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", {31'b0, rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
